// File: rtl/md_scheduler.sv
// HI/LO multiply/divide sequencer: fixed-latency mult/div, mthi/mtlo, and a D-stage stall request.
// Optional madd/maddu accumulate support is compiled in when MDU_MADD_EN is defined.
module md_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        md_use_d,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MADDU = 3'd7
  } md_op_e;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

  // Shared datapath: one multiplier for mult/multu/madd*, one unsigned divider on magnitudes.
  logic        mul_signed, div_signed, neg_a, neg_b;
  logic [63:0] mul_a, mul_b, product;
  logic [31:0] mag_a, mag_b, div_den, q_mag, r_mag, quot, rem;
  logic        start_mdu;

  always_comb begin
    mul_signed = (md_op == OP_MULT) || (md_op == OP_MADD);
    mul_a      = mul_signed ? {{32{src_a[31]}}, src_a} : {32'b0, src_a};
    mul_b      = mul_signed ? {{32{src_b[31]}}, src_b} : {32'b0, src_b};
    product    = mul_a * mul_b;

    // Magnitude form keeps 0x80000000 / -1 well defined: quotient wraps to 0x80000000, rem 0.
    div_signed = (md_op == OP_DIV);
    neg_a      = div_signed && src_a[31];
    neg_b      = div_signed && src_b[31];
    mag_a      = neg_a ? -src_a : src_a;
    mag_b      = neg_b ? -src_b : src_b;
    div_den    = (mag_b == 32'd0) ? 32'd1 : mag_b;
    q_mag      = mag_a / div_den;
    r_mag      = mag_a % div_den;
    quot       = (neg_a ^ neg_b) ? -q_mag : q_mag;
    rem        = neg_a ? -r_mag : r_mag;
  end

  always_comb begin
    start_mdu = start && (md_op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
`ifdef MDU_MADD_EN
    if (start && (md_op inside {OP_MADD, OP_MADDU})) start_mdu = 1'b1;
`endif
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT, OP_MULTU: begin
              {pend_hi_d, pend_lo_d} = product;
              cnt_d   = MULT_N;
              state_d = S_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              if (src_b == 32'd0) {pend_hi_d, pend_lo_d} = {hi_q, lo_q};
              else                {pend_hi_d, pend_lo_d} = {rem, quot};
              cnt_d   = DIV_N;
              state_d = S_BUSY;
            end
            OP_MTHI: hi_d = src_a;
            OP_MTLO: lo_d = src_a;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: begin
              {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + product;
              cnt_d   = MULT_N;
              state_d = S_BUSY;
            end
`endif
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        if (cnt_q <= CNT_ONE) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign busy     = (state_q == S_BUSY);
  assign md_stall = md_use_d && (busy || start_mdu);
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
